// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and init ROM contents for the HD44780 bus scheduler.
package lcd_pkg;

  localparam logic [7:0] FUNC_SET   = 8'h38;
  localparam logic [7:0] DISP_ON    = 8'h0C;
  localparam logic [7:0] DISP_CLR   = 8'h01;
  localparam logic [7:0] ENTRY_MODE = 8'h06;
  localparam logic [7:0] SET_DDRAM  = 8'h80;

  localparam int INIT_DEPTH = 6;

  typedef logic [2:0] init_idx_t;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT_LOAD,
    ST_SETUP,
    ST_EN_HI,
    ST_HOLD,
    ST_EXEC,
    ST_IDLE
  } state_e;

  function automatic logic [7:0] init_rom(input init_idx_t idx);
    case (idx)
      3'd0, 3'd1, 3'd2: init_rom = FUNC_SET;
      3'd3:             init_rom = DISP_ON;
      3'd4:             init_rom = DISP_CLR;
      default:          init_rom = ENTRY_MODE;
    endcase
  endfunction

  // Clear (01) and home (02/03) are the only slow instructions.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    is_slow_cmd = !rs && (data inside {8'h01, 8'h02, 8'h03});
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    max2 = (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Two-way round-robin arbiter with a string lock that pins the grant to one requester.
module lcd_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid_i,
  input  logic       hold_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);

  logic last_q, last_d;
  logic lock_q, lock_d;
  logic owner_q, owner_d;

  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    grant_o = 2'b00;
    if (lock_q) begin
      // Owner keeps the bus even while idle; the other requester simply waits.
      grant_o = owner_q ? 2'b10 : 2'b01;
    end else if (&valid_i) begin
      grant_o = last_q ? 2'b01 : 2'b10;
    end else begin
      grant_o = valid_i;
    end
  end

  always_comb begin
    last_d  = last_q;
    lock_d  = lock_q;
    owner_d = owner_q;
    if (accept_i) begin
      last_d  = grant_o[1];
      owner_d = grant_o[1];
      lock_d  = hold_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q  <= 1'b1;
      lock_q  <= 1'b0;
      owner_q <= 1'b0;
    end else begin
      last_q  <= last_d;
      lock_q  <= lock_d;
      owner_q <= owner_d;
    end
  end

endmodule

// File: rtl/lcd_bus_scheduler.sv
// HD44780 8-bit bus owner: power-up init, then E-pulse timed writes shared by two requesters.
module lcd_bus_scheduler
  import lcd_pkg::*;
#(
  parameter int unsigned T_PWRUP = 4_000_000,
  parameter int unsigned T_INIT1 = 410_000,
  parameter int unsigned T_INIT2 = 10_000,
  parameter int unsigned T_SETUP = 8,
  parameter int unsigned T_EN    = 25,
  parameter int unsigned T_HOLD  = 2,
  parameter int unsigned T_CMD   = 4_000,
  parameter int unsigned T_CLR   = 160_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  input  logic       req0_hold,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  input  logic       req1_hold,
  output logic       req1_ready,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_en,
  output logic       init_done,
  output logic       busy
);

  localparam int unsigned T_MAX =
    max2(max2(max2(T_PWRUP, T_INIT1), max2(T_INIT2, T_SETUP)),
         max2(max2(T_EN, T_HOLD), max2(T_CMD, T_CLR)));
  localparam int CNT_W = $clog2(T_MAX + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  init_idx_t        idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             en_q, en_d;
  logic             init_done_q, init_done_d;

  logic [1:0] grant;
  logic       idle;
  logic       accept;
  logic       sel_hold;
  logic       cnt_last;

  function automatic logic [CNT_W-1:0] exec_wait(input logic booting, input init_idx_t idx,
                                                  input logic rs, input logic [7:0] data);
    if (booting && idx == 3'd0)      exec_wait = CNT_W'(T_INIT1);
    else if (booting && idx == 3'd1) exec_wait = CNT_W'(T_INIT2);
    else if (is_slow_cmd(rs, data))  exec_wait = CNT_W'(T_CLR);
    else                             exec_wait = CNT_W'(T_CMD);
  endfunction

  assign idle     = (state_q == ST_IDLE);
  assign accept   = idle && |(grant & {req1_valid, req0_valid});
  assign sel_hold = grant[1] ? req1_hold : req0_hold;
  assign cnt_last = (cnt_q == CNT_W'(1));

  lcd_rr_arbiter u_arb (
    .clk      (clk),
    .rst      (rst),
    .valid_i  ({req1_valid, req0_valid}),
    .hold_i   (sel_hold),
    .accept_i (accept),
    .grant_o  (grant)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q - CNT_W'(1);
    idx_d       = idx_q;
    data_d      = data_q;
    rs_d        = rs_q;
    init_done_d = init_done_q;
    unique case (state_q)
      ST_PWRUP: begin
        if (cnt_last) state_d = ST_INIT_LOAD;
      end
      ST_INIT_LOAD: begin
        data_d  = init_rom(idx_q);
        rs_d    = 1'b0;
        state_d = ST_SETUP;
        cnt_d   = CNT_W'(T_SETUP);
      end
      ST_SETUP: begin
        if (cnt_last) begin
          state_d = ST_EN_HI;
          cnt_d   = CNT_W'(T_EN);
        end
      end
      ST_EN_HI: begin
        if (cnt_last) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_W'(T_HOLD);
        end
      end
      ST_HOLD: begin
        if (cnt_last) begin
          state_d = ST_EXEC;
          cnt_d   = exec_wait(!init_done_q, idx_q, rs_q, data_q);
        end
      end
      ST_EXEC: begin
        if (cnt_last) begin
          if (init_done_q) begin
            state_d = ST_IDLE;
          end else if (idx_q == init_idx_t'(INIT_DEPTH - 1)) begin
            state_d     = ST_IDLE;
            init_done_d = 1'b1;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_INIT_LOAD;
          end
        end
      end
      ST_IDLE: begin
        cnt_d = cnt_q;
        if (accept) begin
          data_d  = grant[1] ? req1_data : req0_data;
          rs_d    = grant[1] ? req1_rs : req0_rs;
          state_d = ST_SETUP;
          cnt_d   = CNT_W'(T_SETUP);
        end
      end
      default: state_d = ST_PWRUP;
    endcase
  end

  // E comes straight from a flop so it is glitch-free and drops the instant rst rises.
  assign en_d = (state_d == ST_EN_HI);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_PWRUP;
      cnt_q       <= CNT_W'(T_PWRUP);
      idx_q       <= '0;
      data_q      <= '0;
      rs_q        <= 1'b0;
      en_q        <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      rs_q        <= rs_d;
      en_q        <= en_d;
      init_done_q <= init_done_d;
    end
  end

  assign req0_ready = idle && grant[0];
  assign req1_ready = idle && grant[1];
  assign lcd_data   = data_q;
  assign lcd_rs     = rs_q;
  assign lcd_en     = en_q;
  assign init_done  = init_done_q;
  assign busy       = !idle;

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Scoreboard bench: expected LCD bus writes are queued as stimulus is issued and checked on each E pulse.
module tb_lcd_bus_scheduler;
  import lcd_pkg::*;

  localparam int unsigned P_PWRUP = 20;
  localparam int unsigned P_INIT1 = 10;
  localparam int unsigned P_INIT2 = 5;
  localparam int unsigned P_SETUP = 2;
  localparam int unsigned P_EN    = 3;
  localparam int unsigned P_HOLD  = 1;
  localparam int unsigned P_CMD   = 6;
  localparam int unsigned P_CLR   = 15;

  // Rise-to-rise spacing of back-to-back writes: exec + 1 load/accept + setup + E + hold.
  localparam int GAP_CMD = P_CMD + 1 + P_SETUP + P_EN + P_HOLD;
  localparam int GAP_CLR = P_CLR + 1 + P_SETUP + P_EN + P_HOLD;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         gap;
  } exp_t;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    logic       hold;
    int         pause;
  } stim_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req0_rs = 1'b0, req0_hold = 1'b0;
  logic [7:0] req0_data = '0;
  logic       req1_valid = 1'b0, req1_rs = 1'b0, req1_hold = 1'b0;
  logic [7:0] req1_data = '0;
  logic       req0_ready, req1_ready;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_en, init_done, busy;

  exp_t  exp_q[$];
  stim_t sq0[$];
  stim_t sq1[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  lcd_bus_scheduler #(
    .T_PWRUP (P_PWRUP),
    .T_INIT1 (P_INIT1),
    .T_INIT2 (P_INIT2),
    .T_SETUP (P_SETUP),
    .T_EN    (P_EN),
    .T_HOLD  (P_HOLD),
    .T_CMD   (P_CMD),
    .T_CLR   (P_CLR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_rs    (req0_rs),
    .req0_data  (req0_data),
    .req0_hold  (req0_hold),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_rs    (req1_rs),
    .req1_data  (req1_data),
    .req1_hold  (req1_hold),
    .req1_ready (req1_ready),
    .lcd_data   (lcd_data),
    .lcd_rs     (lcd_rs),
    .lcd_en     (lcd_en),
    .init_done  (init_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: compares every E pulse against the scoreboard.
  logic       en_prev = 1'b0;
  int         rise_cyc, first_rise, last_rise;
  int         n_rises = 0;
  logic [8:0] rise_word;
  exp_t       mon_e;

  always @(negedge clk) begin
    if (rst) begin
      en_prev = 1'b0;
      n_rises = 0;
    end else begin
      if (lcd_en && !en_prev) begin
        rise_cyc  = cyc;
        rise_word = {lcd_rs, lcd_data};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bus_unexpected: write rs/data=%h with nothing expected", rise_word);
        end else begin
          mon_e = exp_q.pop_front();
          if (rise_word !== {mon_e.rs, mon_e.data}) begin
            errors++;
            $display("FAIL bus_word: got rs/data=%h expected %h", rise_word, {mon_e.rs, mon_e.data});
          end
          if (mon_e.gap != 0 && n_rises != 0) begin
            checks++;
            if (cyc - last_rise !== mon_e.gap) begin
              errors++;
              $display("FAIL bus_gap: got %0d cycles expected %0d (data %h)",
                       cyc - last_rise, mon_e.gap, mon_e.data);
            end
          end
        end
        if (n_rises == 0) first_rise = cyc;
        last_rise = cyc;
        n_rises++;
      end
      if (!lcd_en && en_prev) begin
        checks++;
        if (cyc - rise_cyc !== P_EN || {lcd_rs, lcd_data} !== rise_word) begin
          errors++;
          $display("FAIL e_pulse: width %0d expected %0d, word %h vs %h at rise",
                   cyc - rise_cyc, P_EN, {lcd_rs, lcd_data}, rise_word);
        end
      end
      en_prev = lcd_en;
    end
  end

  function automatic void push_exp(input logic rs, input logic [7:0] data, input int gap);
    exp_t e;
    e.rs   = rs;
    e.data = data;
    e.gap  = gap;
    exp_q.push_back(e);
  endfunction

  function automatic void push_stim(input int who, input logic rs, input logic [7:0] data,
                                    input logic hold, input int pause);
    stim_t s;
    s.rs    = rs;
    s.data  = data;
    s.hold  = hold;
    s.pause = pause;
    if (who == 0) sq0.push_back(s);
    else          sq1.push_back(s);
  endfunction

  task automatic set_req(input int who, input logic v, input logic rs, input logic [7:0] d,
                         input logic h);
    if (who == 0) begin
      req0_valid = v; req0_rs = rs; req0_data = d; req0_hold = h;
    end else begin
      req1_valid = v; req1_rs = rs; req1_data = d; req1_hold = h;
    end
  endtask

  // Plays one requester's stimulus queue, holding valid until each byte is accepted.
  task automatic run_req(input int who);
    stim_t s;
    logic  got;
    @(negedge clk);
    while ((who == 0 ? sq0.size() : sq1.size()) != 0) begin
      if (who == 0) s = sq0.pop_front();
      else          s = sq1.pop_front();
      if (s.pause > 0) begin
        set_req(who, 1'b0, 1'b0, 8'h00, 1'b0);
        repeat (s.pause) @(negedge clk);
      end
      set_req(who, 1'b1, s.rs, s.data, s.hold);
      got = 1'b0;
      for (int i = 0; i < 400 && !got; i++) begin
        #1;
        if ((who == 0) ? req0_ready : req1_ready) got = 1'b1;
        else @(negedge clk);
      end
      if (!got) begin
        errors++;
        $display("FAIL accept_timeout: requester %0d byte %h never accepted", who, s.data);
      end
      @(posedge clk);
      @(negedge clk);
    end
    set_req(who, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_drain();
    logic done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (!busy && !lcd_en && exp_q.size() == 0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain: busy=%0b pending writes=%0d expected 0", busy, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Applies reset with both requesters waiting, then checks the full init sequence.
  task automatic do_init();
    int   rel;
    logic early = 1'b0;
    logic done  = 1'b0;
    rst = 1'b1;
    set_req(0, 1'b1, 1'b1, 8'hE0, 1'b0);
    set_req(1, 1'b1, 1'b1, 8'hE1, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if ({lcd_data, lcd_rs, lcd_en, req0_ready, req1_ready, init_done, busy} !== {8'h00, 6'b000001}) begin
      errors++;
      $display("FAIL reset_values: data=%h rs=%0b en=%0b rdy=%0b%0b init_done=%0b busy=%0b",
               lcd_data, lcd_rs, lcd_en, req1_ready, req0_ready, init_done, busy);
    end
    push_exp(1'b0, FUNC_SET,   0);
    push_exp(1'b0, FUNC_SET,   P_INIT1 + 7);
    push_exp(1'b0, FUNC_SET,   P_INIT2 + 7);
    push_exp(1'b0, DISP_ON,    GAP_CMD);
    push_exp(1'b0, DISP_CLR,   GAP_CMD);
    push_exp(1'b0, ENTRY_MODE, GAP_CLR);
    rst = 1'b0;
    rel = cyc;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (init_done) done = 1'b1;
      else if (req0_ready || req1_ready) early = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL init_timeout: init_done=%0b expected 1", init_done);
    end
    checks++;
    if (early !== 1'b0) begin
      errors++;
      $display("FAIL init_no_ready: ready seen during init=%0b expected 0", early);
    end
    checks++;
    if (first_rise - rel !== int'(P_PWRUP + 1 + P_SETUP)) begin
      errors++;
      $display("FAIL pwrup_delay: first E at %0d cycles expected %0d", first_rise - rel,
               P_PWRUP + 1 + P_SETUP);
    end
    checks++;
    if (cyc - last_rise !== int'(P_EN + P_HOLD + P_CMD)) begin
      errors++;
      $display("FAIL init_done_time: %0d cycles after last E expected %0d", cyc - last_rise,
               P_EN + P_HOLD + P_CMD);
    end
    checks++;
    if ({req1_ready, req0_ready} !== 2'b01 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL first_grant: ready=%0b%0b pending=%0d expected ready=01 pending=0",
               req1_ready, req0_ready, exp_q.size());
      exp_q.delete();
    end
    set_req(0, 1'b0, 1'b0, 8'h00, 1'b0);
    set_req(1, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset_init();
    do_init();
  endtask

  task automatic test_round_robin();
    push_stim(0, 1'b1, 8'h41, 1'b0, 0);
    push_stim(0, 1'b1, 8'h43, 1'b0, 0);
    push_stim(1, 1'b1, 8'h42, 1'b0, 0);
    push_stim(1, 1'b1, 8'h44, 1'b0, 0);
    push_exp(1'b1, 8'h41, 0);
    push_exp(1'b1, 8'h42, GAP_CMD);
    push_exp(1'b1, 8'h43, GAP_CMD);
    push_exp(1'b1, 8'h44, GAP_CMD);
    fork
      run_req(0);
      run_req(1);
    join
    wait_drain();
  endtask

  task automatic test_single_write();
    int   t;
    int   en_at   = -1;
    int   idle_at = -1;
    logic got     = 1'b0;
    push_exp(1'b1, 8'h35, 0);
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 8'h35, 1'b0);
    for (int i = 0; i < 100 && !got; i++) begin
      #1;
      if (req0_ready) got = 1'b1;
      else @(negedge clk);
    end
    t = cyc;
    @(posedge clk);
    @(negedge clk);
    // Inputs change after the accept edge; the bus must keep the sampled byte.
    set_req(0, 1'b0, 1'b0, 8'hAA, 1'b0);
    checks++;
    if (!got || {lcd_rs, lcd_data} !== {1'b1, 8'h35} || cyc !== t + 1) begin
      errors++;
      $display("FAIL single_latch: accepted=%0b rs/data=%h expected 135 at T+1", got,
               {lcd_rs, lcd_data});
    end
    for (int i = 0; i < 100 && idle_at < 0; i++) begin
      if (lcd_en && en_at < 0) en_at = cyc;
      if (!busy) idle_at = cyc;
      else @(negedge clk);
    end
    checks++;
    if (en_at - t !== 1 + int'(P_SETUP)) begin
      errors++;
      $display("FAIL single_en_rise: E at T+%0d expected T+%0d", en_at - t, 1 + P_SETUP);
    end
    checks++;
    if (idle_at - t !== GAP_CMD) begin
      errors++;
      $display("FAIL single_next_ready: idle at T+%0d expected T+%0d", idle_at - t, GAP_CMD);
    end
    wait_drain();
  endtask

  task automatic test_lock();
    push_stim(1, 1'b1, 8'h61, 1'b1, 0);
    push_stim(1, 1'b1, 8'h62, 1'b1, 0);
    push_stim(1, 1'b1, 8'h63, 1'b0, 20);
    push_stim(0, 1'b1, 8'h50, 1'b0, 0);
    push_exp(1'b1, 8'h61, 0);
    push_exp(1'b1, 8'h62, GAP_CMD);
    push_exp(1'b1, 8'h63, 0);
    push_exp(1'b1, 8'h50, GAP_CMD);
    fork
      run_req(0);
      run_req(1);
    join
    wait_drain();
  endtask

  task automatic test_exec_times();
    push_stim(0, 1'b0, DISP_CLR,  1'b0, 0);
    push_stim(0, 1'b0, SET_DDRAM, 1'b0, 0);
    push_stim(0, 1'b0, 8'h02,     1'b0, 0);
    push_stim(0, 1'b0, 8'h03,     1'b0, 0);
    push_stim(0, 1'b1, 8'h01,     1'b0, 0);
    push_stim(0, 1'b1, 8'h55,     1'b0, 0);
    push_exp(1'b0, DISP_CLR,  0);
    push_exp(1'b0, SET_DDRAM, GAP_CLR);
    push_exp(1'b0, 8'h02,     GAP_CMD);
    push_exp(1'b0, 8'h03,     GAP_CLR);
    push_exp(1'b1, 8'h01,     GAP_CLR);
    push_exp(1'b1, 8'h55,     GAP_CMD);
    run_req(0);
    wait_drain();
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    push_exp(1'b1, 8'h77, 0);
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 8'h77, 1'b0);
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (lcd_en) seen = 1'b1;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (!seen || {lcd_en, init_done, busy, req0_ready} !== 4'b0010) begin
      errors++;
      $display("FAIL reset_abort: E seen=%0b en=%0b init_done=%0b busy=%0b ready0=%0b expected en=0 init_done=0 busy=1",
               seen, lcd_en, init_done, busy, req0_ready);
    end
    do_init();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset_init();
    test_round_robin();
    test_single_write();
    test_lock();
    test_exec_times();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
